// File: rtl/tree_walk_master.sv
// tree_walk_master: walks the node-store binary tree from ROOT_ADDR along path bits and reports the leaf.
// Optional leaf kind write-back is enabled by defining TREE_WALK_WRITEBACK_EN.
module tree_walk_master #(
   parameter int         MAX_DEPTH = 8,
   parameter logic [4:0] ROOT_ADDR = 5'd0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MAX_DEPTH-1:0] path,
   input  logic [1:0]           set_kind,
   input  logic [11:0]          read_node,
   output logic [4:0]           read_addr,
   output logic [11:0]          write_node,
   output logic [4:0]           write_addr,
   output logic                 write,
   output logic                 busy,
   output logic                 done,
   output logic [4:0]           leaf_addr,
   output logic [1:0]           leaf_kind,
   output logic [3:0]           depth_out,
   output logic                 err
);
`ifdef TREE_WALK_WRITEBACK_EN
   typedef enum logic [2:0] {IDLE, FETCH, DECIDE, WRITE, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, FETCH, DECIDE, DONE} state_t;
   logic unused_set_kind;
   assign unused_set_kind = ^set_kind;
   assign write      = 1'b0;
   assign write_addr = 5'd0;
   assign write_node = 12'd0;
`endif
   state_t               state;
   logic [11:0]          node_q;
   logic [MAX_DEPTH-1:0] path_q;
   logic [4:0]           cur_addr;
   logic [3:0]           depth;
   logic [15:0]          path_x;
   logic [4:0]           child;
   logic                 is_leaf;
   logic                 stop;
   always_comb begin
      path_x  = 16'(path_q);
      child   = path_x[depth] ? node_q[6:2] : node_q[11:7];
      is_leaf = node_q[1:0] != 2'b11;
      stop    = is_leaf || child == ROOT_ADDR || depth == 4'(MAX_DEPTH - 1);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         node_q     <= '0;
         path_q     <= '0;
         cur_addr   <= ROOT_ADDR;
         depth      <= '0;
         read_addr  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         leaf_addr  <= '0;
         leaf_kind  <= '0;
         depth_out  <= '0;
         err        <= 1'b0;
`ifdef TREE_WALK_WRITEBACK_EN
         write      <= 1'b0;
         write_addr <= '0;
         write_node <= '0;
`endif
      end else begin
         done  <= 1'b0;
`ifdef TREE_WALK_WRITEBACK_EN
         write <= 1'b0;
`endif
         case (state)
            IDLE: if (start) begin
               state     <= FETCH;
               cur_addr  <= ROOT_ADDR;
               read_addr <= ROOT_ADDR;
               depth     <= '0;
               path_q    <= path;
               err       <= 1'b0;
               busy      <= 1'b1;
            end
            FETCH: begin
               node_q <= read_node;
               state  <= DECIDE;
            end
            DECIDE: if (stop) begin
               // null child and depth overflow both report the internal node reached
               leaf_addr <= cur_addr;
               leaf_kind <= node_q[1:0];
               depth_out <= depth;
               err       <= !is_leaf;
`ifdef TREE_WALK_WRITEBACK_EN
               state     <= is_leaf ? WRITE : DONE;
`else
               state     <= DONE;
`endif
            end else begin
               cur_addr  <= child;
               read_addr <= child;
               depth     <= depth + 4'd1;
               state     <= FETCH;
            end
`ifdef TREE_WALK_WRITEBACK_EN
            WRITE: begin
               write      <= 1'b1;
               write_addr <= cur_addr;
               write_node <= {node_q[11:2], set_kind};
               state      <= DONE;
            end
`endif
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tree_walk_master.sv
// tb_tree_walk_master: table-driven walks against a preloaded node store, scoreboarded on done.
module tb_tree_walk_master;
`ifdef TREE_WALK_WRITEBACK_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  path = '0;
   logic [1:0]  set_kind = '0;
   logic [11:0] read_node;
   logic [4:0]  read_addr, write_addr, leaf_addr;
   logic [11:0] write_node;
   logic        write, busy, done, err;
   logic [1:0]  leaf_kind;
   logic [3:0]  depth_out;
   logic [11:0] mem [32];
   int checks = 0;
   int failures = 0;

   tree_walk_master #(.MAX_DEPTH(8), .ROOT_ADDR(5'd0)) dut (
      .clk(clk), .reset(reset), .start(start), .path(path), .set_kind(set_kind),
      .read_node(read_node), .read_addr(read_addr), .write_node(write_node),
      .write_addr(write_addr), .write(write), .busy(busy), .done(done),
      .leaf_addr(leaf_addr), .leaf_kind(leaf_kind), .depth_out(depth_out), .err(err)
   );

   always #5 clk = ~clk;
   assign read_node = mem[read_addr];
   always @(posedge clk) if (write) mem[write_addr] <= write_node;

   typedef struct {
      logic [7:0]  path;
      logic        loop;
      logic [1:0]  kind_set;
      logic [4:0]  addr;
      logic [1:0]  kind;
      logic [3:0]  dep;
      logic        err;
      int          lat;
      logic        wr;
      logic [11:0] wnode;
      logic        poke;
   } vec_t;
   typedef struct {
      logic [4:0] addr;
      logic [1:0] kind;
      logic [3:0] dep;
      logic       err;
   } exp_t;
   exp_t sb[$];
   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, want);
      end
   endtask

   task automatic preload();
      for (int i = 0; i < 32; i++) mem[i] = 12'h000;
      mem[0] = 12'h08B;
      mem[1] = 12'h001;
      mem[2] = 12'h193;
      mem[3] = 12'h002;
      mem[4] = 12'h003;
   endtask

   task automatic run(input vec_t v);
      int   cnt, lat, wn, wcyc;
      logic got;
      logic [4:0]  wa;
      logic [11:0] wd;
      exp_t e;
      preload();
      if (v.loop) mem[1] = 12'h087;
      sb.push_back('{v.addr, v.kind, v.dep, v.err});
      lat = v.lat + ((WB && v.wr) ? 1 : 0);
      @(posedge clk);
      #1 path = v.path; set_kind = v.kind_set; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cnt = 0; wn = 0; wcyc = 0; got = 1'b0; wa = '0; wd = '0;
      @(negedge clk);
      chk("busy_set", busy, 1);
      chk("read_root", read_addr, 0);
      while (cnt < 40 && !got) begin
         @(posedge clk);
         cnt++;
         #1 start = v.poke && (cnt == 2 || cnt == lat - 1);
         @(negedge clk);
         if (write) begin wn++; wcyc = cnt; wa = write_addr; wd = write_node; end
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", got, 1);
      if (got) begin
         chk("latency", cnt, lat);
         chk("busy_drop", busy, 0);
         if (sb.size() == 0) chk("sb_empty", 0, 1);
         else begin
            e = sb.pop_front();
            chk("leaf_addr", leaf_addr, e.addr);
            chk("leaf_kind", leaf_kind, e.kind);
            chk("depth_out", depth_out, e.dep);
            chk("err", err, e.err);
         end
      end
      chk("write_count", wn, (WB && v.wr) ? 1 : 0);
      if (WB && v.wr) begin
         chk("write_cycle", wcyc, lat - 1);
         chk("write_addr", wa, v.addr);
         chk("write_node", wd, v.wnode);
         chk("store_updated", mem[v.addr], v.wnode);
      end
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("result_held", leaf_addr, v.addr);
      if (v.poke) repeat (3) begin
         @(negedge clk);
         chk("no_restart", busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'b000, 1'b0, 2'b10, 5'd1, 2'b01, 4'd1, 1'b0, 5,  1'b1, 12'h002, 1'b0};
      tbl[1] = '{8'b001, 1'b0, 2'b01, 5'd3, 2'b10, 4'd2, 1'b0, 7,  1'b1, 12'h001, 1'b0};
      tbl[2] = '{8'b011, 1'b0, 2'b00, 5'd4, 2'b11, 4'd2, 1'b1, 7,  1'b0, 12'h000, 1'b0};
      tbl[3] = '{8'b000, 1'b1, 2'b00, 5'd1, 2'b11, 4'd7, 1'b1, 17, 1'b0, 12'h000, 1'b0};
      tbl[4] = '{8'b101, 1'b0, 2'b11, 5'd3, 2'b10, 4'd2, 1'b0, 7,  1'b1, 12'h003, 1'b1};
      preload();
      #3 reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_read_addr", read_addr, 0);
      chk("rst_leaf_addr", leaf_addr, 0);
      chk("rst_err", err, 0);
      chk("rst_write", write, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) run(tbl[i]);
      // abort a walk mid-flight: outputs clear at once, nothing completes or writes
      preload();
      @(posedge clk);
      #1 path = 8'b0; set_kind = 2'b10; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_read_addr", read_addr, 0);
      chk("abort_leaf_addr", leaf_addr, 0);
      chk("abort_leaf_kind", leaf_kind, 0);
      chk("abort_depth", depth_out, 0);
      chk("abort_err", err, 0);
      chk("abort_write", write, 0);
      chk("abort_write_node", write_node, 0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_no_write", write, 0);
      end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_idle", busy, 0);
         chk("abort_store", mem[1], 12'h001);
      end
      run(tbl[1]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
